// File: rtl/bus_scratchpad_slave_if.sv
// System-bus signal bundle between a bus master (jtag_support) and the scratchpad slave.
// Pure wiring: no storage, no latency.
// Backpressure: master stalls read data with busyIN; slave reports busyOUT (always 0 here).
`timescale 1ns/1ps
interface bus_scratchpad_slave_if;
  // master -> slave
  logic        begin_transactionIN;
  logic [31:0] address_dataIN;
  logic        read_n_writeIN;
  logic [3:0]  byte_enableIN;
  logic [7:0]  burst_sizeIN;
  logic        data_validIN;
  logic        end_transactionIN;
  logic        busyIN;
  // slave -> master
  logic [31:0] address_dataOUT;
  logic        data_validOUT;
  logic        end_transactionOUT;
  logic        busyOUT;
  logic        errorOUT;

  modport master (
    output begin_transactionIN, address_dataIN, read_n_writeIN, byte_enableIN,
           burst_sizeIN, data_validIN, end_transactionIN, busyIN,
    input  address_dataOUT, data_validOUT, end_transactionOUT, busyOUT, errorOUT
  );

  modport slave (
    input  begin_transactionIN, address_dataIN, read_n_writeIN, byte_enableIN,
           burst_sizeIN, data_validIN, end_transactionIN, busyIN,
    output address_dataOUT, data_validOUT, end_transactionOUT, busyOUT, errorOUT
  );
endinterface

// File: rtl/bus_scratchpad_slave.sv
// Word-organised scratchpad RAM slave serving single/burst reads and byte-enabled writes.
// Latency: first read word 2 cycles after begin; writes land on the data_validIN cycle.
// Backpressure: busyIN freezes the read pipeline; the slave itself never stalls (busyOUT=0).
`timescale 1ns/1ps
module bus_scratchpad_slave #(
  parameter logic [31:0] BASE_ADDRESS = 32'h5000_0000,
  parameter int          SIZE_WORDS   = 1024
) (
  input  logic                         system_clock,
  input  logic                         system_reset,
  bus_scratchpad_slave_if.slave        bus
);

  localparam int AW = $clog2(SIZE_WORDS);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WRITE  = 3'd1,
    READ   = 3'd2,
    RD_END = 3'd3,
    ERR    = 3'd4
  } state_t;

  state_t        state_q;
  logic [AW-1:0] ptr_q;     // word index of the next RAM access
  logic [8:0]    cnt_q;     // beats written, or words fetched for a read
  logic [8:0]    len_q;     // burst length in beats (burst_sizeIN + 1)
  logic [3:0]    be_q;      // byte enables latched for the whole burst
  logic [31:0]   rdata_q;
  logic          rvalid_q;
  logic          end_q;
  logic          err_q;

  // RAM is deliberately not reset; contents survive system_reset.
  logic [31:0]   mem_q [SIZE_WORDS];

  logic          hit_d;
  logic [AW-1:0] idx_d;
  logic [12:0]   last_idx_d;
  logic          range_err_d;
  logic [8:0]    len_d;
  logic          wr_beat_d;
  logic          rd_step_d;
  logic          unused_addr_lsbs;

  // Decode of the begin cycle: region hit, start word, and the burst's last word.
  // The last-word sum is kept wide so a burst running off the top is caught, never wrapped.
  assign hit_d       = (bus.address_dataIN[31:AW+2] == BASE_ADDRESS[31:AW+2]);
  assign idx_d       = bus.address_dataIN[AW+1:2];
  assign last_idx_d  = 13'(idx_d) + 13'(bus.burst_sizeIN);
  assign range_err_d = (last_idx_d > 13'(SIZE_WORDS - 1));
  assign len_d       = {1'b0, bus.burst_sizeIN} + 9'd1;

  // Byte address bits [1:0] carry no meaning for a word-organised RAM.
  assign unused_addr_lsbs = ^bus.address_dataIN[1:0];

  // A write beat is taken only while the burst still has room; extra beats are dropped.
  assign wr_beat_d = (state_q == WRITE) && bus.data_validIN && (cnt_q != len_q);

  // The read output register may advance when empty or when its word is being accepted.
  assign rd_step_d = !rvalid_q || !bus.busyIN;

  // Transaction sequencing with registered bus outputs (all zero outside our transaction)
  always_ff @(posedge system_clock or posedge system_reset) begin
    if (system_reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
      be_q     <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      end_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          rdata_q  <= '0;
          rvalid_q <= 1'b0;
          end_q    <= 1'b0;
          err_q    <= 1'b0;
          if (bus.begin_transactionIN && hit_d) begin
            ptr_q <= idx_d;
            cnt_q <= '0;
            len_q <= len_d;
            be_q  <= bus.byte_enableIN;
            if (range_err_d) begin
              state_q <= ERR;
              end_q   <= 1'b1;
              err_q   <= 1'b1;
            end else if (bus.read_n_writeIN) begin
              state_q <= READ;
            end else begin
              state_q <= WRITE;
            end
          end
        end

        WRITE: begin
          if (wr_beat_d) begin
            ptr_q <= ptr_q + AW'(1);
            cnt_q <= cnt_q + 9'd1;
          end
          // A beat arriving with the end strobe is still written (RAM block below).
          if (bus.end_transactionIN) begin
            state_q <= IDLE;
          end
        end

        READ: begin
          if (bus.end_transactionIN) begin
            // Master abort: drop off the bus immediately, no closing pulse.
            state_q  <= IDLE;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
          end else if (rd_step_d) begin
            if (cnt_q != len_q) begin
              rdata_q  <= mem_q[ptr_q];
              rvalid_q <= 1'b1;
              ptr_q    <= ptr_q + AW'(1);
              cnt_q    <= cnt_q + 9'd1;
            end else begin
              // Last word has just been accepted.
              state_q  <= RD_END;
              rdata_q  <= '0;
              rvalid_q <= 1'b0;
              end_q    <= 1'b1;
            end
          end
        end

        RD_END: begin
          end_q   <= 1'b0;
          state_q <= IDLE;
        end

        ERR: begin
          end_q   <= 1'b0;
          err_q   <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          state_q  <= IDLE;
          rdata_q  <= '0;
          rvalid_q <= 1'b0;
          end_q    <= 1'b0;
          err_q    <= 1'b0;
        end
      endcase
    end
  end

  // Scratchpad storage: byte-lane writes during an accepted write beat
  always_ff @(posedge system_clock) begin
    if (wr_beat_d) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) begin
          mem_q[ptr_q][8*i +: 8] <= bus.address_dataIN[8*i +: 8];
        end
      end
    end
  end

  assign bus.address_dataOUT    = rdata_q;
  assign bus.data_validOUT      = rvalid_q;
  assign bus.end_transactionOUT = end_q;
  assign bus.errorOUT           = err_q;
  assign bus.busyOUT            = 1'b0;

endmodule

// File: tb/tb_bus_scratchpad_slave.sv
// Directed bench for bus_scratchpad_slave: table of single-word accesses plus burst,
// stall, abort, range-error, miss and mid-burst reset sequences.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
`timescale 1ns/1ps
module tb_bus_scratchpad_slave;

  logic clk;
  logic rst;

  bus_scratchpad_slave_if bus ();

  bus_scratchpad_slave #(
    .BASE_ADDRESS (32'h5000_0000),
    .SIZE_WORDS   (1024)
  ) dut (
    .system_clock (clk),
    .system_reset (rst),
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  typedef struct {
    logic        rnw;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;   // write data, or expected read data
  } vec_t;

  vec_t        vecs[13];
  logic [31:0] wr_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] rd_q[$];
  int          rd_lat;
  int          stall_vis;
  logic        rd_hold_bad;
  logic        rd_timeout;
  logic        rd_end_after_valid;
  logic        rd_valid_at_end;
  logic        rd_end_twice;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  function automatic logic [35:0] outs();
    return {bus.data_validOUT, bus.end_transactionOUT, bus.busyOUT, bus.errorOUT,
            bus.address_dataOUT};
  endfunction

  task automatic idle_inputs();
    bus.begin_transactionIN = 1'b0;
    bus.address_dataIN      = '0;
    bus.read_n_writeIN      = 1'b0;
    bus.byte_enableIN       = '0;
    bus.burst_sizeIN        = '0;
    bus.data_validIN        = 1'b0;
    bus.end_transactionIN   = 1'b0;
    bus.busyIN              = 1'b0;
  endtask

  // Write burst: begin, then one beat per wr_q entry, end strobe on the last beat.
  task automatic do_write(input logic [31:0] addr, input logic [3:0] be, input logic [7:0] burst);
    bus.begin_transactionIN = 1'b1;
    bus.address_dataIN      = addr;
    bus.read_n_writeIN      = 1'b0;
    bus.byte_enableIN       = be;
    bus.burst_sizeIN        = burst;
    @(negedge clk);
    bus.begin_transactionIN = 1'b0;
    bus.byte_enableIN       = '0;
    bus.burst_sizeIN        = '0;
    for (int i = 0; i < wr_q.size(); i++) begin
      bus.data_validIN      = 1'b1;
      bus.address_dataIN    = wr_q[i];
      bus.end_transactionIN = (i == wr_q.size() - 1);
      @(negedge clk);
    end
    idle_inputs();
    @(negedge clk);
  endtask

  // Read burst collector; beat stall_beat is held off with busyIN for stall_cycles samples.
  task automatic do_read(input logic [31:0] addr, input logic [7:0] burst,
                         input int stall_beat, input int stall_cycles);
    int          cyc;
    int          beat;
    int          stall_left;
    logic        done;
    logic        prev_valid;
    logic [31:0] held;
    rd_q.delete();
    rd_lat             = -1;
    stall_vis          = 0;
    rd_hold_bad        = 1'b0;
    rd_end_after_valid = 1'b0;
    rd_valid_at_end    = 1'b0;
    held               = '0;
    prev_valid         = 1'b0;
    bus.begin_transactionIN = 1'b1;
    bus.address_dataIN      = addr;
    bus.read_n_writeIN      = 1'b1;
    bus.byte_enableIN       = 4'hF;
    bus.burst_sizeIN        = burst;
    @(negedge clk);
    idle_inputs();
    cyc        = 1;
    beat       = 0;
    stall_left = stall_cycles;
    done       = 1'b0;
    while (!done && cyc < 600) begin
      if (bus.end_transactionOUT) begin
        done               = 1'b1;
        rd_end_after_valid = prev_valid;
        rd_valid_at_end    = bus.data_validOUT;
      end else if (bus.data_validOUT) begin
        if (rd_lat < 0) rd_lat = cyc;
        if (beat == stall_beat) begin
          stall_vis++;
          if (stall_vis > 1 && bus.address_dataOUT !== held) rd_hold_bad = 1'b1;
          held = bus.address_dataOUT;
        end
        if (beat == stall_beat && stall_left > 0) begin
          bus.busyIN = 1'b1;
          stall_left--;
        end else begin
          bus.busyIN = 1'b0;
          rd_q.push_back(bus.address_dataOUT);
          beat++;
        end
      end else begin
        bus.busyIN = 1'b0;
      end
      prev_valid = bus.data_validOUT;
      @(negedge clk);
      cyc++;
    end
    bus.busyIN   = 1'b0;
    rd_timeout   = !done;
    rd_end_twice = bus.end_transactionOUT;
  endtask

  task automatic check_read(input string nm);
    logic [31:0] act;
    check({nm, " timeout"}, rd_timeout, 1'b0);
    check({nm, " beats"}, rd_q.size(), exp_q.size());
    check({nm, " latency"}, rd_lat, 2);
    check({nm, " end_after_last"}, rd_end_after_valid, 1'b1);
    check({nm, " valid_at_end"}, rd_valid_at_end, 1'b0);
    check({nm, " end_once"}, rd_end_twice, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      act = (i < rd_q.size()) ? rd_q[i] : 32'hxxxx_xxxx;
      check($sformatf("%s data[%0d]", nm, i), act, exp_q[i]);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [35:0] acc;
    checks = 0;
    errors = 0;

    vecs[0]  = '{1'b0, 32'h5000_0010, 4'hF, 32'hDEAD_BEEF};
    vecs[1]  = '{1'b1, 32'h5000_0010, 4'hF, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b0, 32'h5000_0014, 4'hF, 32'h1122_3344};
    vecs[3]  = '{1'b0, 32'h5000_0014, 4'h5, 32'hAABB_CCDD};
    vecs[4]  = '{1'b1, 32'h5000_0014, 4'hF, 32'h11BB_33DD};
    vecs[5]  = '{1'b0, 32'h5000_0FFC, 4'hF, 32'hCAFE_F00D};
    vecs[6]  = '{1'b1, 32'h5000_0FFC, 4'hF, 32'hCAFE_F00D};
    vecs[7]  = '{1'b0, 32'h5000_0000, 4'hF, 32'h0000_0001};
    vecs[8]  = '{1'b0, 32'h5000_0003, 4'hA, 32'h1234_5678};
    vecs[9]  = '{1'b1, 32'h5000_0002, 4'hF, 32'h1200_5601};
    vecs[10] = '{1'b0, 32'h5000_0FF8, 4'hF, 32'h0BAD_C0DE};
    vecs[11] = '{1'b0, 32'h5000_0020, 4'hF, 32'h5A5A_5A5A};
    vecs[12] = '{1'b0, 32'h5000_0020, 4'h0, 32'hFFFF_FFFF};

    idle_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset outputs", outs(), 36'h0);
    rst = 1'b0;
    @(negedge clk);

    // Single-word table
    for (int i = 0; i < 13; i++) begin
      if (!vecs[i].rnw) begin
        wr_q = '{vecs[i].data};
        do_write(vecs[i].addr, vecs[i].be, 8'd0);
      end else begin
        exp_q = '{vecs[i].data};
        do_read(vecs[i].addr, 8'd0, -1, 0);
        check_read($sformatf("vec%0d", i));
      end
    end
    exp_q = '{32'h5A5A_5A5A};
    do_read(32'h5000_0020, 8'd0, -1, 0);
    check_read("be_zero");

    // 16-word burst write then read back
    wr_q.delete();
    for (int i = 0; i < 16; i++) wr_q.push_back(32'hB000_0000 | (i * 32'h0001_0203));
    do_write(32'h5000_0100, 4'hF, 8'd15);
    exp_q = wr_q;
    do_read(32'h5000_0100, 8'd15, -1, 0);
    check_read("burst16");

    // 4-word read with the second beat stalled 3 cycles
    exp_q = '{wr_q[0], wr_q[1], wr_q[2], wr_q[3]};
    do_read(32'h5000_0100, 8'd3, 1, 3);
    check_read("stall");
    check("stall visible cycles", stall_vis, 4);
    check("stall hold stable", rd_hold_bad, 1'b0);

    // Extra write beats beyond the burst length are discarded
    wr_q = '{32'h7777_7777};
    do_write(32'h5000_0034, 4'hF, 8'd0);
    wr_q = '{32'hA1A1_A1A1, 32'hB2B2_B2B2, 32'hC3C3_C3C3};
    do_write(32'h5000_0030, 4'hF, 8'd0);
    exp_q = '{32'hA1A1_A1A1, 32'h7777_7777};
    do_read(32'h5000_0030, 8'd1, -1, 0);
    check_read("overrun");

    // Out-of-range read: 1022 + 3 > 1023
    bus.begin_transactionIN = 1'b1;
    bus.address_dataIN      = 32'h5000_0FF8;
    bus.read_n_writeIN      = 1'b1;
    bus.burst_sizeIN        = 8'd3;
    @(negedge clk);
    idle_inputs();
    check("range rd pulse", outs(), {4'b0101, 32'h0});
    @(negedge clk);
    check("range rd after", outs(), 36'h0);
    @(negedge clk);

    // Top-of-region burst that just fits
    exp_q = '{32'h0BAD_C0DE, 32'hCAFE_F00D};
    do_read(32'h5000_0FF8, 8'd1, -1, 0);
    check_read("top_fit");

    // Out-of-range write: following data beats must not reach the RAM
    bus.begin_transactionIN = 1'b1;
    bus.address_dataIN      = 32'h5000_0FFC;
    bus.read_n_writeIN      = 1'b0;
    bus.byte_enableIN       = 4'hF;
    bus.burst_sizeIN        = 8'd1;
    @(negedge clk);
    idle_inputs();
    check("range wr pulse", outs(), {4'b0101, 32'h0});
    bus.data_validIN   = 1'b1;
    bus.address_dataIN = 32'hFFFF_FFFF;
    @(negedge clk);
    check("range wr after", outs(), 36'h0);
    bus.end_transactionIN = 1'b1;
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    exp_q = '{32'hCAFE_F00D};
    do_read(32'h5000_0FFC, 8'd0, -1, 0);
    check_read("range_wr_ram");

    // Address miss: read then write outside the region
    bus.begin_transactionIN = 1'b1;
    bus.address_dataIN      = 32'h6000_0000;
    bus.read_n_writeIN      = 1'b1;
    @(negedge clk);
    idle_inputs();
    acc = '0;
    for (int i = 0; i < 4; i++) begin
      acc = acc | outs();
      @(negedge clk);
    end
    check("miss outputs", acc, 36'h0);
    wr_q = '{32'h0000_0000};
    do_write(32'h6000_0010, 4'hF, 8'd0);
    exp_q = '{32'hDEAD_BEEF};
    do_read(32'h5000_0010, 8'd0, -1, 0);
    check_read("miss_wr_ram");

    // Read abort by the master after the first beat
    bus.begin_transactionIN = 1'b1;
    bus.address_dataIN      = 32'h5000_0100;
    bus.read_n_writeIN      = 1'b1;
    bus.burst_sizeIN        = 8'd7;
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    check("abort first valid", bus.data_validOUT, 1'b1);
    bus.end_transactionIN = 1'b1;
    @(negedge clk);
    bus.end_transactionIN = 1'b0;
    check("abort next", outs(), 36'h0);
    @(negedge clk);
    check("abort no end", outs(), 36'h0);

    // Reset in the middle of an 8-beat read
    bus.begin_transactionIN = 1'b1;
    bus.address_dataIN      = 32'h5000_0100;
    bus.read_n_writeIN      = 1'b1;
    bus.burst_sizeIN        = 8'd7;
    @(negedge clk);
    idle_inputs();
    repeat (3) @(negedge clk);
    check("pre-reset valid", bus.data_validOUT, 1'b1);
    rst = 1'b1;
    #1;
    check("reset mid-burst", outs(), 36'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("after reset", outs(), 36'h0);
    exp_q = '{32'hB000_0000 | 32'h0001_0203};
    do_read(32'h5000_0104, 8'd0, -1, 0);
    check_read("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
